// File: rtl/ge_pkg.sv
// Shared Ed25519 group-element declarations: field width, the 2*d
// constant in 10-limb form, and the state encoding for ge_p3_to_cached.
package ge_pkg;

  localparam int FE_W  = 320;
  localparam int LIMBS = 10;

  typedef logic [FE_W-1:0] fe_t;

  // 2*d, limb 9 first so that limb 0 lands in the low 32 bits
  localparam fe_t D2 = {
    32'sd9444199,
    32'sd29715968,
    -32'sd6495438,
    -32'sd12551817,
    32'sd15978800,
    32'sd229458,
    32'sd13898782,
    -32'sd30745221,
    -32'sd5839606,
    -32'sd21827239
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_MUL_WAIT,
    ST_FIN
  } p3c_state_e;

endpackage

// File: rtl/ge_p3_to_cached.sv
// P3 -> cached conversion: sequences shared fe_add/fe_sub/fe_mulx
// to produce (Y+X, Y-X, Z, 2d*T).
module ge_p3_to_cached
  import ge_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            valid,
  input  logic [FE_W-1:0] p_x,
  input  logic [FE_W-1:0] p_y,
  input  logic [FE_W-1:0] p_z,
  input  logic [FE_W-1:0] p_t,
  input  logic            p_error,
  output logic [FE_W-1:0] c_yplusx,
  output logic [FE_W-1:0] c_yminusx,
  output logic [FE_W-1:0] c_z,
  output logic [FE_W-1:0] c_t2d,
  output logic            error,
  output logic            done,
  output logic [FE_W-1:0] mul_op_a,
  output logic [FE_W-1:0] mul_op_b,
  output logic            mul_valid,
  input  logic [FE_W-1:0] mul_res,
  input  logic            mul_done,
  output logic [FE_W-1:0] add_op_a,
  output logic [FE_W-1:0] add_op_b,
  input  logic [FE_W-1:0] add_res,
  output logic [FE_W-1:0] sub_op_a,
  output logic [FE_W-1:0] sub_op_b,
  input  logic [FE_W-1:0] sub_res
);

  p3c_state_e state_q;
  p3c_state_e state_d;

  fe_t  xr;
  fe_t  yr;
  fe_t  zr;
  fe_t  tr;
  logic er;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (valid) state_d = ST_CALC;
      ST_CALC:     state_d = er ? ST_FIN : ST_MUL_WAIT;
      ST_MUL_WAIT: if (mul_done) state_d = ST_FIN;
      ST_FIN:      state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Multiplier operands stay put from issue until the result returns
  always_comb begin
    mul_valid = 1'b0;
    mul_op_a  = '0;
    mul_op_b  = '0;
    done      = 1'b0;
    unique case (state_q)
      ST_CALC: begin
        mul_valid = ~er;
        if (!er) begin
          mul_op_a = tr;
          mul_op_b = D2;
        end
      end
      ST_MUL_WAIT: begin
        mul_op_a = tr;
        mul_op_b = D2;
      end
      ST_FIN:  done = 1'b1;
      default: ;
    endcase
  end

  assign add_op_a = yr;
  assign add_op_b = xr;
  assign sub_op_a = yr;
  assign sub_op_b = xr;

  always_ff @(posedge clk) begin
    if (rst) begin
      xr        <= '0;
      yr        <= '0;
      zr        <= '0;
      tr        <= '0;
      er        <= 1'b0;
      c_yplusx  <= '0;
      c_yminusx <= '0;
      c_z       <= '0;
      c_t2d     <= '0;
      error     <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (valid) begin
            xr <= p_x;
            yr <= p_y;
            zr <= p_z;
            tr <= p_t;
            er <= p_error;
          end
        end
        ST_CALC: begin
          if (er) begin
            c_yplusx  <= '0;
            c_yminusx <= '0;
            c_z       <= '0;
            c_t2d     <= '0;
            error     <= 1'b1;
          end else begin
            c_yplusx  <= add_res;
            c_yminusx <= sub_res;
            c_z       <= zr;
          end
        end
        ST_MUL_WAIT: begin
          if (mul_done) begin
            c_t2d <= mul_res;
            error <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ge_p3_to_cached.sv
// Randomized bench for ge_p3_to_cached with limb-wise add/sub stubs
// and a variable-latency multiplier stub.
module tb_ge_p3_to_cached;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         valid;
  logic [319:0] p_x, p_y, p_z, p_t;
  logic         p_error;
  logic [319:0] c_yplusx, c_yminusx, c_z, c_t2d;
  logic         error, done;
  logic [319:0] mul_op_a, mul_op_b, mul_res;
  logic         mul_valid, mul_done;
  logic [319:0] add_op_a, add_op_b, add_res;
  logic [319:0] sub_op_a, sub_op_b, sub_res;

  ge_p3_to_cached dut (
    .clk(clk), .rst(rst), .valid(valid),
    .p_x(p_x), .p_y(p_y), .p_z(p_z), .p_t(p_t),
    .p_error(p_error),
    .c_yplusx(c_yplusx), .c_yminusx(c_yminusx),
    .c_z(c_z), .c_t2d(c_t2d),
    .error(error), .done(done),
    .mul_op_a(mul_op_a), .mul_op_b(mul_op_b),
    .mul_valid(mul_valid), .mul_res(mul_res),
    .mul_done(mul_done),
    .add_op_a(add_op_a), .add_op_b(add_op_b),
    .add_res(add_res),
    .sub_op_a(sub_op_a), .sub_op_b(sub_op_b),
    .sub_res(sub_res)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [319:0] d2_ref;
  int d2_tab [10] = '{-21827239, -5839606, -30745221,
                      13898782, 229458, 15978800, -12551817,
                      -6495438, 29715968, 9444199};

  function automatic logic [319:0] fe_add_m(
    input logic [319:0] a, input logic [319:0] b);
    logic [319:0] r;
    for (int i = 0; i < 10; i++)
      r[32*i +: 32] = a[32*i +: 32] + b[32*i +: 32];
    return r;
  endfunction

  function automatic logic [319:0] fe_sub_m(
    input logic [319:0] a, input logic [319:0] b);
    logic [319:0] r;
    for (int i = 0; i < 10; i++)
      r[32*i +: 32] = a[32*i +: 32] - b[32*i +: 32];
    return r;
  endfunction

  // Stand-in multiplier: plain integer product truncated to 320 bits
  function automatic logic [319:0] fe_mul_m(
    input logic [319:0] a, input logic [319:0] b);
    logic [639:0] p;
    p = {320'b0, a} * {320'b0, b};
    return p[319:0];
  endfunction

  function automatic logic [319:0] rnd_fe();
    logic [319:0] r;
    for (int i = 0; i < 10; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  assign add_res = fe_add_m(add_op_a, add_op_b);
  assign sub_res = fe_sub_m(sub_op_a, sub_op_b);

  int           lat    = 1;
  int           remain = 0;
  logic [319:0] sa, sb;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    mul_done <= 1'b0;
    if (mul_valid) begin
      sa     <= mul_op_a;
      sb     <= mul_op_b;
      remain <= lat;
    end else if (remain == 1) begin
      mul_done <= 1'b1;
      mul_res  <= fe_mul_m(sa, sb);
      remain   <= 0;
    end else if (remain > 1) begin
      remain <= remain - 1;
    end
  end

  int           mv_cnt = 0;
  int           done_cnt = 0;
  int           stab_err = 0;
  logic [319:0] mvb;

  always @(negedge clk) begin
    if (mul_valid) begin
      mv_cnt++;
      mvb = mul_op_b;
    end
    if (done) done_cnt++;
    if (remain > 0 && mul_op_a !== sa) stab_err++;
  end

  task automatic check(input string tag,
                       input logic [319:0] got,
                       input logic [319:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic run_op(input logic [319:0] x, input logic [319:0] y,
                        input logic [319:0] z, input logic [319:0] t,
                        input logic e, input int l, input bit dup);
    int  v;
    int  dcyc;
    bit  got;
    lat      = l;
    @(negedge clk);
    mv_cnt   = 0;
    done_cnt = 0;
    stab_err = 0;
    p_x = x; p_y = y; p_z = z; p_t = t;
    p_error = e;
    valid = 1'b1;
    v = cyc;
    @(negedge clk);
    p_x = rnd_fe(); p_y = rnd_fe();
    p_z = rnd_fe(); p_t = rnd_fe();
    p_error = ~e;
    valid = dup;
    @(negedge clk);
    valid = 1'b0;
    got  = 1'b0;
    dcyc = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      if (done) begin
        got  = 1'b1;
        dcyc = cyc;
      end else begin
        @(negedge clk);
      end
    end
    if (!got) begin
      check("done_timeout", 320'(got), 320'(1));
      return;
    end
    check("latency", 320'(dcyc - v), 320'(e ? 2 : 3 + l));
    check("error", 320'(error), 320'(e));
    check("yplusx", c_yplusx, e ? '0 : fe_add_m(y, x));
    check("yminusx", c_yminusx, e ? '0 : fe_sub_m(y, x));
    check("z", c_z, e ? '0 : z);
    check("t2d", c_t2d, e ? '0 : fe_mul_m(t, d2_ref));
    check("mul_valid_cnt", 320'(mv_cnt), 320'(e ? 0 : 1));
    check("mul_op_a_stable", 320'(stab_err), 320'(0));
    if (!e) check("mul_op_b", mvb, d2_ref);
    repeat (3) @(negedge clk);
    check("done_cnt", 320'(done_cnt), 320'(1));
  endtask

  logic [319:0] one;

  initial begin
    for (int i = 0; i < 10; i++) d2_ref[32*i +: 32] = d2_tab[i];
    one = 320'd1;
    rst = 1'b1; valid = 1'b0; p_error = 1'b0;
    p_x = '0; p_y = '0; p_z = '0; p_t = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_done", 320'(done), 320'(0));
    check("rst_error", 320'(error), 320'(0));
    check("rst_mul_valid", 320'(mul_valid), 320'(0));
    check("rst_mul_op_a", mul_op_a, '0);
    check("rst_c", c_yplusx | c_yminusx | c_z | c_t2d, '0);

    run_op('0, one, one, '0, 1'b0, 1, 1'b0);
    run_op('0, one, one, one, 1'b0, 1, 1'b0);
    check("t2d_is_d2", c_t2d, d2_ref);
    run_op(rnd_fe(), rnd_fe(), rnd_fe(), rnd_fe(), 1'b1, 1, 1'b0);
    run_op(rnd_fe(), rnd_fe(), rnd_fe(), rnd_fe(), 1'b0, 20, 1'b1);
    run_op(rnd_fe(), rnd_fe(), rnd_fe(), rnd_fe(), 1'b1, 3, 1'b1);

    lat = 10;
    @(negedge clk);
    p_x = rnd_fe(); p_y = rnd_fe(); p_z = rnd_fe(); p_t = rnd_fe();
    p_error = 1'b0;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    check("abort_done", 320'(done), 320'(0));
    check("abort_error", 320'(error), 320'(0));
    check("abort_mul_valid", 320'(mul_valid), 320'(0));
    check("abort_c", c_yplusx | c_yminusx | c_z | c_t2d, '0);
    repeat (20) @(negedge clk);
    check("abort_no_done", 320'(done_cnt), 320'(0));

    for (int k = 0; k < 20; k++)
      run_op(rnd_fe(), rnd_fe(), rnd_fe(), rnd_fe(),
             logic'($urandom_range(3) == 0),
             int'($urandom_range(8, 1)), bit'($urandom_range(1)));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
